// File: rtl/uc_fp_add.sv
// uc_fp_add: control FSM for the binary32 adder datapath; drives mux selects,
// alignment/normalization shifts, exponent adjust and rounding, with one renormalization pass.
module uc_fp_add (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [31:0] operando_a,
  input  logic [31:0] operando_b,
  input  logic [7:0]  exp_dif,
  input  logic [26:0] ula,
  input  logic [26:0] round_fract,
  output logic        sinalMuxFP1,
  output logic        sinalMuxFP2,
  output logic        sinalMuxFP3,
  output logic        sinalMuxFP4,
  output logic        sinalMuxFP5,
  output logic [7:0]  sinalShiftFract,
  output logic [8:0]  sinalShiftRes,
  output logic [8:0]  sinalIncOrDec,
  output logic        sinalRound,
  output logic        ocupado,
  output logic        pronto,
  output logic        zero
);
  typedef enum logic [2:0] {IDLE, SOMA, NORMALIZA, ARREDONDA, VERIFICA, RENORMALIZA, FIM} state_t;
  state_t state_q, state_d;
  logic fp1_q, fp1_d, fp2_q, fp2_d, fp3_q, fp3_d, fp4_q, fp4_d, fp5_q, fp5_d;
  logic round_q, round_d, ocupado_q, ocupado_d, pronto_q, pronto_d, zero_q, zero_d;
  logic [7:0] shift_fract_q, shift_fract_d, lz;
  logic [8:0] shift_res_q, shift_res_d, inc_dec_q, inc_dec_d;
  logic b_larger;
  always_comb begin
    lz = 8'd25;
    for (int i = 0; i < 26; i++)
      if (ula[i]) lz = 8'(25 - i);
  end
  assign b_larger = operando_b[30:0] > operando_a[30:0];
  always_comb begin
    state_d       = state_q;
    fp1_d         = fp1_q;
    fp2_d         = fp2_q;
    fp3_d         = fp3_q;
    fp4_d         = fp4_q;
    fp5_d         = fp5_q;
    shift_fract_d = shift_fract_q;
    shift_res_d   = shift_res_q;
    inc_dec_d     = inc_dec_q;
    round_d       = round_q;
    zero_d        = zero_q;
    pronto_d      = 1'b0;
    case (state_q)
      IDLE: if (iniciar) begin
        state_d       = SOMA;
        fp1_d         = operando_a[30:23] < operando_b[30:23];
        fp2_d         = b_larger;
        fp3_d         = ~b_larger;
        fp4_d         = 1'b0;
        fp5_d         = 1'b0;
        shift_fract_d = exp_dif > 8'd27 ? 8'd27 : exp_dif;
        round_d       = 1'b0;
        zero_d        = 1'b0;
      end
      SOMA: begin
        state_d     = NORMALIZA;
        zero_d      = ula == '0;
        shift_res_d = ula == '0 ? 9'h100 : ula[26] ? 9'h001 : {1'b1, lz};
        inc_dec_d   = ula == '0 ? 9'h000 : ula[26] ? 9'h001 : {1'b1, lz};
      end
      NORMALIZA: begin
        state_d = ARREDONDA;
        round_d = 1'b1;
      end
      ARREDONDA: state_d = VERIFICA;
      VERIFICA: if (round_fract[26]) begin
        state_d     = RENORMALIZA;
        fp4_d       = 1'b1;
        fp5_d       = 1'b1;
        shift_res_d = 9'h001;
        inc_dec_d   = 9'h001;
        round_d     = 1'b0;
      end else state_d = FIM;
      RENORMALIZA: state_d = FIM;
      FIM: begin
        state_d  = IDLE;
        pronto_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ocupado_d = state_d != IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      fp1_q         <= 1'b0;
      fp2_q         <= 1'b0;
      fp3_q         <= 1'b0;
      fp4_q         <= 1'b0;
      fp5_q         <= 1'b0;
      shift_fract_q <= '0;
      shift_res_q   <= 9'h100;
      inc_dec_q     <= 9'h000;
      round_q       <= 1'b0;
      ocupado_q     <= 1'b0;
      pronto_q      <= 1'b0;
      zero_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fp1_q         <= fp1_d;
      fp2_q         <= fp2_d;
      fp3_q         <= fp3_d;
      fp4_q         <= fp4_d;
      fp5_q         <= fp5_d;
      shift_fract_q <= shift_fract_d;
      shift_res_q   <= shift_res_d;
      inc_dec_q     <= inc_dec_d;
      round_q       <= round_d;
      ocupado_q     <= ocupado_d;
      pronto_q      <= pronto_d;
      zero_q        <= zero_d;
    end
  end
  assign sinalMuxFP1     = fp1_q;
  assign sinalMuxFP2     = fp2_q;
  assign sinalMuxFP3     = fp3_q;
  assign sinalMuxFP4     = fp4_q;
  assign sinalMuxFP5     = fp5_q;
  assign sinalShiftFract = shift_fract_q;
  assign sinalShiftRes   = shift_res_q;
  assign sinalIncOrDec   = inc_dec_q;
  assign sinalRound      = round_q;
  assign ocupado         = ocupado_q;
  assign pronto          = pronto_q;
  assign zero            = zero_q;
endmodule
